// File: rtl/mem_wb_latch.sv
// MEM/WB pipeline register with memory-completion handshake, completion timeout and halt freeze.
// Optional performance counters are built when MEMWB_PERF_EN is defined.
module mem_wb_latch #(
   parameter int MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic [15:0] ALU,
   input  logic [15:0] readData,
   input  logic        Done_DM,
   input  logic        MemToReg,
   input  logic        RegWrite,
   input  logic [2:0]  WriteReg,
   input  logic        HaltSig,
   input  logic        err_in,
   output logic        Stall_MEM,
   output logic        wb_valid,
   output logic [15:0] wb_data,
   output logic        wb_RegWrite,
   output logic [2:0]  wb_WriteReg,
   output logic        wb_halt,
   output logic        wb_err,
   output logic [7:0]  wait_cnt,
   output logic [15:0] perf_stall,
   output logic [15:0] perf_retire,
   output logic [1:0]  fsm_state
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      WAIT   = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

   state_t state;
   logic   halted;
   logic   cap_normal;
   logic   cap_timeout;
   logic   capture;

   // Upstream is frozen while completion is pending, and forever once halted.
   always_comb begin
      halted      = (state == HALTED);
      Stall_MEM   = (mem_valid & ~Done_DM & ~halted) | halted;
      cap_normal  = Done_DM & (((state == RUN) & mem_valid) | (state == WAIT));
      cap_timeout = (state == WAIT) & ~Done_DM & (wait_cnt >= MAX_W);
      capture     = cap_normal | cap_timeout;
   end

   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         wait_cnt    <= 8'd0;
         wb_valid    <= 1'b0;
         wb_data     <= 16'd0;
         wb_RegWrite <= 1'b0;
         wb_WriteReg <= 3'd0;
         wb_halt     <= 1'b0;
         wb_err      <= 1'b0;
      end else begin
         wb_valid    <= 1'b0;
         wb_RegWrite <= 1'b0;
         case (state)
            RUN: begin
               if (mem_valid & ~Done_DM) begin
                  state    <= WAIT;
                  wait_cnt <= 8'd1;
               end
            end
            WAIT: begin
               if (capture) begin
                  state    <= RUN;
                  wait_cnt <= 8'd0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: begin
               state <= HALTED;
            end
         endcase
         if (capture) begin
            wb_valid    <= 1'b1;
            wb_WriteReg <= WriteReg;
            // A timed-out access retires as a non-writing error carrying the address.
            wb_data     <= (cap_normal & MemToReg) ? readData : ALU;
            wb_RegWrite <= cap_normal & RegWrite;
            wb_err      <= cap_timeout | err_in;
            if (HaltSig) begin
               wb_halt <= 1'b1;
               state   <= HALTED;
            end
         end
      end
   end

`ifdef MEMWB_PERF_EN
   logic [15:0] stall_q;
   logic [15:0] retire_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q  <= 16'd0;
         retire_q <= 16'd0;
      end else begin
         if (Stall_MEM & ~halted & (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
         if (capture & (retire_q != 16'hFFFF))
            retire_q <= retire_q + 16'd1;
      end
   end

   assign perf_stall  = stall_q;
   assign perf_retire = retire_q;
`else
   assign perf_stall  = 16'd0;
   assign perf_retire = 16'd0;
`endif

endmodule

// File: tb/tb_mem_wb_latch.sv
// Randomized scoreboard bench for mem_wb_latch: per-instruction latency model, directed
// miss/timeout/boundary/halt/reset cases, and a monitor that pops expected retires.
module tb_mem_wb_latch;
   localparam int MAX_WAIT = 4;
   localparam int W = 22;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_valid = 1'b0;
   logic [15:0] ALU = 16'd0;
   logic [15:0] readData = 16'd0;
   logic        Done_DM = 1'b0;
   logic        MemToReg = 1'b0;
   logic        RegWrite = 1'b0;
   logic [2:0]  WriteReg = 3'd0;
   logic        HaltSig = 1'b0;
   logic        err_in = 1'b0;
   logic        Stall_MEM;
   logic        wb_valid;
   logic [15:0] wb_data;
   logic        wb_RegWrite;
   logic [2:0]  wb_WriteReg;
   logic        wb_halt;
   logic        wb_err;
   logic [7:0]  wait_cnt;
   logic [15:0] perf_stall;
   logic [15:0] perf_retire;
   logic [1:0]  fsm_state;

   // Expected retire: {data[15:0], reg[2:0], regwrite, err, halt}
   logic [W-1:0] exp_q[$];
   int checks = 0;
   int fails = 0;
   int exp_stall = 0;
   int exp_retire = 0;

   mem_wb_latch #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .ALU(ALU), .readData(readData),
      .Done_DM(Done_DM), .MemToReg(MemToReg), .RegWrite(RegWrite), .WriteReg(WriteReg),
      .HaltSig(HaltSig), .err_in(err_in), .Stall_MEM(Stall_MEM), .wb_valid(wb_valid),
      .wb_data(wb_data), .wb_RegWrite(wb_RegWrite), .wb_WriteReg(wb_WriteReg),
      .wb_halt(wb_halt), .wb_err(wb_err), .wait_cnt(wait_cnt), .perf_stall(perf_stall),
      .perf_retire(perf_retire), .fsm_state(fsm_state)
   );

   // Clock / reset block
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_perf();
`ifdef MEMWB_PERF_EN
      check("perf_stall", perf_stall, exp_stall);
      check("perf_retire", perf_retire, exp_retire);
`else
      check("perf_stall_tied", perf_stall, 0);
      check("perf_retire_tied", perf_retire, 0);
`endif
   endtask

   task automatic check_zero();
      check("rst_wb_valid", wb_valid, 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_wb_regwrite", wb_RegWrite, 0);
      check("rst_wb_writereg", wb_WriteReg, 0);
      check("rst_wb_halt", wb_halt, 0);
      check("rst_wb_err", wb_err, 0);
      check("rst_wait_cnt", wait_cnt, 0);
      check("rst_state", fsm_state, 0);
      check("rst_stall", Stall_MEM, 0);
      check_perf();
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      mem_valid = 1'b0;
      HaltSig = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      exp_stall = 0;
      exp_retire = 0;
      #1 check_zero();
   endtask

   // Drives one instruction whose memory access stays incomplete for d cycles.
   // Model: d <= MAX_WAIT retires normally after d+1 cycles; otherwise it retires as a
   // timeout error after MAX_WAIT+1 incomplete cycles.
   task automatic issue(input logic [15:0] alu, input logic [15:0] rd, input logic m2r,
                        input logic rw, input logic [2:0] wr, input logic halt,
                        input logic err, input int d);
      bit to;
      int low;
      to  = (d > MAX_WAIT);
      low = to ? MAX_WAIT + 1 : d;
      if (to) exp_q.push_back({alu, wr, 1'b0, 1'b1, halt});
      else    exp_q.push_back({(m2r ? rd : alu), wr, rw, err, halt});
      exp_stall  += low;
      exp_retire += 1;
      ALU = alu; MemToReg = m2r; RegWrite = rw; WriteReg = wr; HaltSig = halt; err_in = err;
      for (int c = 0; c < low; c++) begin
         mem_valid = 1'b1;
         Done_DM = 1'b0;
         readData = 16'($urandom);
         #1 check("stall_pending", Stall_MEM, 1);
         tick();
         if (!(to && c == low - 1)) begin
            check("wait_cnt", wait_cnt, c + 1);
            check("bubble_valid", wb_valid, 0);
         end
      end
      if (!to) begin
         mem_valid = 1'b1;
         Done_DM = 1'b1;
         readData = rd;
         #1 check("stall_done", Stall_MEM, 0);
         tick();
      end
      mem_valid = 1'b0;
      Done_DM = 1'b0;
      HaltSig = 1'b0;
      readData = 16'($urandom);
      check("wait_cnt_after", wait_cnt, 0);
      check("state_after", fsm_state, halt ? 2 : 0);
      @(negedge clk);
      #1 check("retire_on_time", exp_q.size(), 0);
   endtask

   // Scoreboard monitor: pops one expected entry per retire
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("regwrite_gated", wb_RegWrite & ~wb_valid, 0);
            if (wb_valid) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  fails++;
                  $display("FAIL unexpected_retire: got wb_data 0x%0h, expected no retire at %0t",
                           wb_data, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("wb_data", wb_data, e[21:6]);
                  check("wb_writereg", wb_WriteReg, e[5:3]);
                  check("wb_regwrite", wb_RegWrite, e[2]);
                  check("wb_err", wb_err, e[1]);
                  check("wb_halt", wb_halt, e[0]);
               end
            end
         end
      end
   end

   initial begin
      tick();
      reset_dut();

      // Plain ALU op, then a 3-cycle load miss
      issue(16'h1234, 16'h5555, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 0);
      issue(16'h0040, 16'hBEEF, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 3);
      check_perf();

      // Timeout, then completion on the timeout cycle itself
      issue(16'hA5A5, 16'h1111, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, MAX_WAIT + 1);
      issue(16'h0F0F, 16'h2222, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, MAX_WAIT);
      check_perf();

      // Randomized instruction stream with idle gaps
      for (int n = 0; n < 40; n++) begin
         issue(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b0,
               1'($urandom_range(0, 1)), $urandom_range(0, MAX_WAIT + 2));
         repeat ($urandom_range(0, 2)) begin
            mem_valid = 1'b0;
            Done_DM = 1'($urandom_range(0, 1));
            #1 check("stall_idle", Stall_MEM, 0);
            tick();
            check("idle_valid", wb_valid, 0);
         end
      end
      check_perf();

      // Reset on the second WAIT cycle aborts the access without a capture
      ALU = 16'h7777; MemToReg = 1'b1; RegWrite = 1'b1; WriteReg = 3'd7;
      mem_valid = 1'b1; Done_DM = 1'b0;
      tick();
      tick();
      check("mid_wait_cnt", wait_cnt, 2);
      rst = 1'b1; Done_DM = 1'b1; readData = 16'hDEAD;
      tick();
      rst = 1'b0; mem_valid = 1'b0; Done_DM = 1'b0;
      exp_stall = 0;
      exp_retire = 0;
      #1 check_zero();

      // Halt retires once, then everything freezes until reset
      issue(16'h0BAD, 16'hC0DE, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1);
      for (int c = 0; c < 4; c++) begin
         mem_valid = 1'($urandom_range(0, 1));
         Done_DM = 1'b1;
         readData = 16'($urandom);
         #1 check("halt_stall", Stall_MEM, 1);
         tick();
         check("halt_sticky", wb_halt, 1);
         check("halt_no_valid", wb_valid, 0);
         check("halt_state", fsm_state, 2);
      end
      check_perf();
      reset_dut();

      repeat (2) tick();
      check("final_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
